torture_vpu_commit_reader: RTL



---
 rtl/torture_vpu_trace_pkg.sv | 64 ++++++
 rtl/torture_vpu_commit_reader_if.sv | 14 +
 rtl/torture_vpu_evq.sv | 47 ++++
 rtl/torture_vpu_commit_reader.sv | 121 ++++++++++++
 4 files changed

// File: rtl/torture_vpu_trace_pkg.sv
// torture_vpu_trace_pkg: shared types, header layout and beat arithmetic for the VPU torture trace
package torture_vpu_trace_pkg;

    localparam int N_LANES        = 4;
    localparam int LANE_DW        = 64;
    localparam int VADDR_WIDTH    = 5;
    localparam int SB_WIDTH       = 4;
    localparam int CSR_VSEW_WIDTH = 3;
    localparam int CSR_VLEN_WIDTH = 8;
    localparam int EVQ_DEPTH      = 4;
    localparam int CHUNK_WIDTH    = 7;
    localparam int BEATS_WIDTH    = 8;
    localparam int BEAT_DW        = N_LANES * LANE_DW;
    localparam int BEAT_BYTES     = BEAT_DW / 8;
    localparam int BYTES_WIDTH    = CSR_VLEN_WIDTH + 5;

    localparam int HDR_SB_LSB     = 0;
    localparam int HDR_VREG_LSB   = 4;
    localparam int HDR_SEW_LSB    = 9;
    localparam int HDR_VLEN_LSB   = 12;
    localparam int HDR_WIDEN_BIT  = 20;
    localparam int HDR_ILL_BIT    = 21;
    localparam int HDR_BEATS_LSB  = 22;

    typedef struct packed {
        logic                      illegal;
        logic [VADDR_WIDTH-1:0]    vreg;
        logic [CSR_VSEW_WIDTH-1:0] sew;
        logic [CSR_VLEN_WIDTH-1:0] vlen;
        logic                      widening;
        logic [SB_WIDTH-1:0]       sb_id;
    } evt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_CAP,
        ST_OUT
    } state_t;

    // Bytes of the destination group rounded up to whole beats; the widest
    // case (vlen=255, 64-bit, widening) lands exactly on 128 beats.
    function automatic logic [BEATS_WIDTH-1:0] beat_count(input evt_t e);
        logic [BYTES_WIDTH-1:0] bytes;
        bytes = BYTES_WIDTH'(e.vlen) << e.sew;
        if (e.widening) bytes = bytes << 1;
        return e.illegal ? '0 : BEATS_WIDTH'((bytes + BYTES_WIDTH'(BEAT_BYTES - 1)) / BYTES_WIDTH'(BEAT_BYTES));
    endfunction

    function automatic logic [BEAT_DW-1:0] make_header(input evt_t e, input logic [BEATS_WIDTH-1:0] beats);
        logic [BEAT_DW-1:0] h;
        h = '0;
        h[HDR_SB_LSB +: SB_WIDTH]          = e.sb_id;
        h[HDR_VREG_LSB +: VADDR_WIDTH]     = e.vreg;
        h[HDR_SEW_LSB +: CSR_VSEW_WIDTH]   = e.sew;
        h[HDR_VLEN_LSB +: CSR_VLEN_WIDTH]  = e.vlen;
        h[HDR_WIDEN_BIT]                   = e.widening;
        h[HDR_ILL_BIT]                     = e.illegal;
        h[HDR_BEATS_LSB +: BEATS_WIDTH]    = beats;
        return h;
    endfunction

endpackage

// File: rtl/torture_vpu_commit_reader_if.sv
// torture_vpu_commit_reader_if: valid/ready trace stream carrying header and data beats
interface torture_vpu_commit_reader_if;
    import torture_vpu_trace_pkg::*;

    logic               valid;
    logic               ready;
    logic               hdr;
    logic               last;
    logic [BEAT_DW-1:0] data;

    modport master (output valid, hdr, last, data, input ready);
    modport slave  (input valid, hdr, last, data, output ready);

endinterface

// File: rtl/torture_vpu_evq.sv
// torture_vpu_evq: completion event FIFO that accepts a push into a full queue when a pop frees a slot that cycle
module torture_vpu_evq
    import torture_vpu_trace_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  evt_t din,
    output evt_t dout,
    output logic empty,
    output logic ovf
);
    localparam int AW = $clog2(EVQ_DEPTH);

    evt_t        mem [EVQ_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointers advance on accepted pushes/pops; a rejected push latches the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_push) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/torture_vpu_commit_reader.sv
// torture_vpu_commit_reader: turns VPU writeback completions into header+data trace packets read back from the VRF
module torture_vpu_commit_reader
    import torture_vpu_trace_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        completed_valid,
    input  logic                        completed_illegal,
    input  logic [VADDR_WIDTH-1:0]      vreg_dst,
    input  logic [CSR_VSEW_WIDTH-1:0]   sew,
    input  logic [CSR_VLEN_WIDTH-1:0]   vlen,
    input  logic                        widening,
    input  logic [SB_WIDTH-1:0]         sb_id,
    output logic                        vrf_rd_req,
    output logic [VADDR_WIDTH-1:0]      vrf_rd_vreg,
    output logic [CHUNK_WIDTH-1:0]      vrf_rd_chunk,
    input  logic [BEAT_DW-1:0]          vrf_rd_data,
    torture_vpu_commit_reader_if.master trc,
    output logic                        evq_ovf
);
    state_t                 state;
    evt_t                   evt_in;
    evt_t                   head;
    logic                   empty;
    logic                   pop;
    logic [BEATS_WIDTH-1:0] head_beats;
    logic [BEATS_WIDTH-1:0] beats;
    logic [CHUNK_WIDTH-1:0] chunk;
    logic [VADDR_WIDTH-1:0] vreg;
    logic                   last_chunk;

    assign evt_in     = '{illegal: completed_illegal, vreg: vreg_dst, sew: sew, vlen: vlen,
                          widening: widening, sb_id: sb_id};
    assign pop        = (state == ST_IDLE) && !empty;
    assign head_beats = beat_count(head);
    assign last_chunk = {1'b0, chunk} == beats - 1'b1;

    torture_vpu_evq u_evq (
        .clk   (clk),
        .rst   (rst),
        .push  (completed_valid),
        .pop   (pop),
        .din   (evt_in),
        .dout  (head),
        .empty (empty),
        .ovf   (evq_ovf)
    );

    // Packet sequencer: header, then one RD/CAP/OUT round per data beat; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            beats        <= '0;
            chunk        <= '0;
            vreg         <= '0;
            vrf_rd_req   <= 1'b0;
            vrf_rd_vreg  <= '0;
            vrf_rd_chunk <= '0;
            trc.valid    <= 1'b0;
            trc.hdr      <= 1'b0;
            trc.last     <= 1'b0;
            trc.data     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        vreg      <= head.vreg;
                        beats     <= head_beats;
                        trc.valid <= 1'b1;
                        trc.hdr   <= 1'b1;
                        trc.last  <= head_beats == '0;
                        trc.data  <= make_header(head, head_beats);
                        state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (trc.ready) begin
                        trc.valid <= 1'b0;
                        trc.hdr   <= 1'b0;
                        trc.last  <= 1'b0;
                        if (beats == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            chunk        <= '0;
                            vrf_rd_req   <= 1'b1;
                            vrf_rd_vreg  <= vreg;
                            vrf_rd_chunk <= '0;
                            state        <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    vrf_rd_req <= 1'b0;
                    state      <= ST_CAP;
                end
                ST_CAP: begin
                    trc.data  <= vrf_rd_data;
                    trc.valid <= 1'b1;
                    trc.last  <= last_chunk;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (trc.ready) begin
                        trc.valid <= 1'b0;
                        trc.last  <= 1'b0;
                        if (trc.last) begin
                            state <= ST_IDLE;
                        end else begin
                            chunk        <= chunk + 1'b1;
                            vrf_rd_req   <= 1'b1;
                            vrf_rd_chunk <= chunk + 1'b1;
                            state        <= ST_RD;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
